// File: rtl/traffic_phase_scheduler.sv
// Highway/country-road phase sequencer: tick-paced dwell timer, pedestrian latch,
// emergency preempt, and Moore lamp decode from the state register.
module traffic_phase_scheduler #(
    parameter int MIN_HWY_GREEN  = 8,
    parameter int MAX_CTRY_GREEN = 16,
    parameter int YELLOW_TIME    = 3,
    parameter int ALL_RED_TIME   = 2,
    parameter int WALK_TIME      = 4,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       car_sense,
    input  logic       ped_req,
    input  logic       preempt,
    output logic [1:0] hwy,
    output logic [1:0] contry,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    // Last timer value of each dwell; parameters up to 2^CNT_W still fit after the -1.
    localparam logic [CNT_W-1:0] HG_LAST   = CNT_W'(MIN_HWY_GREEN - 1);
    localparam logic [CNT_W-1:0] CG_LAST   = CNT_W'(MAX_CTRY_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_TIME - 1);
    localparam logic [CNT_W:0]   WALK_LIM  = (CNT_W + 1)'(WALK_TIME);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_pending_q, ped_pending_d;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        ped_pending_d = ped_pending_q | ped_req;
        if (state_q > AR2) begin
            state_d = HG;
            timer_d = '0;
        end else if (tick) begin
            case (state_q)
                HG: begin
                    if (timer_q != HG_LAST)
                        timer_d = timer_q + 1'b1;
                    else if ((car_sense || ped_pending_q) && !preempt)
                        state_d = HY;
                end
                HY:  if (timer_q == YEL_LAST) state_d = AR1; else timer_d = timer_q + 1'b1;
                AR1: if (timer_q == AR_LAST)  state_d = preempt ? AR2 : CG;
                     else timer_d = timer_q + 1'b1;
                CG: begin
                    if (preempt || timer_q == CG_LAST || (!car_sense && timer_q >= WALK_LAST))
                        state_d = CY;
                    else
                        timer_d = timer_q + 1'b1;
                end
                CY:  if (timer_q == YEL_LAST) state_d = AR2; else timer_d = timer_q + 1'b1;
                default: if (timer_q == AR_LAST) state_d = HG; else timer_d = timer_q + 1'b1;
            endcase
            if (state_d != state_q)
                timer_d = '0;
        end
        // A request arriving on the CG-entry clock survives the clear.
        if (state_d == CG && state_q != CG)
            ped_pending_d = ped_req;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= HG;
            timer_q       <= '0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    always_comb begin
        hwy    = RED;
        contry = RED;
        case (state_q)
            HG:      hwy    = GREEN;
            HY:      hwy    = YELLOW;
            CG:      contry = GREEN;
            CY:      contry = YELLOW;
            default: ;
        endcase
    end

    assign walk  = (state_q == CG) && ({1'b0, timer_q} < WALK_LIM);
    assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic,
// compared every cycle against a tick-counting phase model.
module tb_traffic_phase_scheduler;

    localparam int MIN  = 8;
    localparam int MAXC = 16;
    localparam int YEL  = 3;
    localparam int AR   = 2;
    localparam int WALK = 4;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       clr = 1'b1;
    logic       tick = 1'b1;
    logic       car = 1'b0;
    logic       ped = 1'b0;
    logic       pre = 1'b0;
    logic [1:0] hwy, contry;
    logic       walk;
    logic [2:0] phase;

    int passed = 0;
    int total  = 0;

    // Model: phase number, ticks spent in the phase (HG capped at MIN), pending flag.
    int m_ph  = 0;
    int m_el  = 0;
    bit m_ped = 1'b0;

    traffic_phase_scheduler dut (
        .clk       (clk),
        .clr       (clr),
        .tick      (tick),
        .car_sense (car),
        .ped_req   (ped),
        .preempt   (pre),
        .hwy       (hwy),
        .contry    (contry),
        .walk      (walk),
        .phase     (phase)
    );

    always #5 clk = clk_run ? ~clk : clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ph  = 0;
        m_el  = 0;
        m_ped = 1'b0;
    endtask

    task automatic model_step();
        int done;
        int nph;
        bit nped;
        nped = m_ped | ped;
        nph  = m_ph;
        if (m_ph > 5) begin
            nph  = 0;
            m_el = 0;
        end else if (tick) begin
            done = m_el + 1;
            case (m_ph)
                0: if (done >= MIN && (car || m_ped) && !pre) nph = 1;
                1: if (done == YEL) nph = 2;
                2: if (done == AR) nph = pre ? 5 : 3;
                3: if (pre || done == MAXC || (!car && done >= WALK)) nph = 4;
                4: if (done == YEL) nph = 5;
                default: if (done == AR) nph = 0;
            endcase
            if (nph != m_ph) m_el = 0;
            else m_el = (m_ph == 0 && done > MIN) ? MIN : done;
        end
        if (nph == 3 && m_ph != 3) nped = ped;
        m_ph  = nph;
        m_ped = nped;
    endtask

    task automatic check_outs(input string tag);
        logic [1:0] eh, ec;
        logic       ew;
        eh = (m_ph == 0) ? 2'b10 : (m_ph == 1) ? 2'b01 : 2'b00;
        ec = (m_ph == 3) ? 2'b10 : (m_ph == 4) ? 2'b01 : 2'b00;
        ew = (m_ph == 3) && (m_el < WALK);
        check(tag, {hwy, contry, walk, phase}, {eh, ec, ew, 3'(m_ph)});
        check({tag, "_ped"}, {7'b0, dut.ped_pending_q}, {7'b0, m_ped});
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_outs(tag);
    endtask

    task automatic run(input string tag, input int n);
        repeat (n) cycle(tag);
    endtask

    task automatic run_until(input string tag, input int ph, input int bound);
        int k;
        k = 0;
        while (m_ph != ph && k < bound) begin
            cycle(tag);
            k++;
        end
        total++;
        assert (m_ph == ph) passed++;
        else $error("FAIL %s_timeout observed=%0d expected=%0d", tag, m_ph, ph);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #1;
        model_reset();
        check_outs("reset");
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int hy_cycles;
        // Power-on reset
        #2;
        do_reset();

        // Car arrival: 8 HG, 3 HY, 2 AR1, 16 CG, 3 CY, 2 AR2
        car = 1'b1;
        run("car", 8);  check("car_hy",  {5'b0, phase}, 8'd1);
        run("car", 3);  check("car_ar1", {5'b0, phase}, 8'd2);
        run("car", 2);  check("car_cg",  {5'b0, phase}, 8'd3);
        run("car", 16); check("car_cy",  {5'b0, phase}, 8'd4);
        run("car", 3);  check("car_ar2", {5'b0, phase}, 8'd5);
        run("car", 2);  check("car_hg",  {5'b0, phase}, 8'd0);

        // Early country exit
        do_reset();
        car = 1'b1;
        run_until("early", 3, 40);
        car = 1'b0;
        run("early", 3);
        check("early_walk", {7'b0, walk}, 8'd1);
        cycle("early");
        check("early_cy", {5'b0, phase}, 8'd4);

        // Pedestrian only
        do_reset();
        car = 1'b0;
        cycle("ped");
        ped = 1'b1;
        cycle("ped");
        ped = 1'b0;
        run("ped", 6);
        check("ped_hy", {5'b0, phase}, 8'd1);
        run_until("ped", 3, 20);
        check("ped_clr", {7'b0, dut.ped_pending_q}, 8'd0);
        run_until("ped", 0, 40);
        ped = 1'b1;
        cycle("ped");
        ped = 1'b0;
        run_until("ped", 2, 40);
        while (!(m_ph == 2 && m_el == AR - 1)) cycle("ped");
        ped = 1'b1;
        cycle("ped");
        ped = 1'b0;
        check("ped_second", {7'b0, dut.ped_pending_q}, 8'd1);
        run("ped", 30);

        // Preempt holds HG, diverts AR1 to AR2, cuts CG
        do_reset();
        car = 1'b1;
        pre = 1'b1;
        run("pre_hold", 30);
        check("pre_hold", {5'b0, phase}, 8'd0);
        pre = 1'b0;
        run_until("pre_ar1", 2, 20);
        pre = 1'b1;
        run("pre_ar1", 2);
        check("pre_ar2", {5'b0, phase}, 8'd5);
        pre = 1'b0;
        run_until("pre_cg", 3, 40);
        run("pre_cg", 2);
        pre = 1'b1;
        cycle("pre_cg");
        check("pre_cy", {5'b0, phase}, 8'd4);
        pre = 1'b0;

        // Tick every 4th cycle
        do_reset();
        car = 1'b1;
        hy_cycles = 0;
        for (int i = 0; i < 120; i++) begin
            tick = (i % 4 == 0);
            cycle("tick4");
            if (phase == 3'd1) hy_cycles++;
        end
        check("tick4_hy_len", 8'(hy_cycles), 8'd12);
        tick = 1'b1;

        // Random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) car = ~car;
            ped = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 39) == 0) pre = ~pre;
            cycle("rand");
        end
        tick = 1'b1;
        ped  = 1'b0;
        pre  = 1'b0;

        // Illegal phase code recovers to HG
        do_reset();
        car = 1'b1;
        pre = 1'b1;
        run("force", 2);
        force dut.state_q = 3'd6;
        #1;
        m_ph = 6;
        check("force_lamps", {hwy, contry, phase}, {2'b00, 2'b00, 3'd6});
        release dut.state_q;
        cycle("force");
        check("force_hg", {5'b0, phase}, 8'd0);
        pre = 1'b0;

        // Asynchronous reset mid-CG with the clock stopped
        do_reset();
        car = 1'b1;
        run_until("async", 3, 40);
        run("async", 3);
        @(negedge clk);
        clk_run = 1'b0;
        #7;
        clr = 1'b1;
        #1;
        check("async_clr", {hwy, contry, walk, phase}, {2'b10, 2'b00, 1'b0, 3'd0});
        model_reset();
        #2;
        clr = 1'b0;
        #2;
        clk_run = 1'b1;
        run("async_after", 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Timed phase sequencer for the highway/country-road intersection. It generates the highway and country signal codes and a pedestrian walk output, using tick-counted dwell times in place of simulation delays. Inputs are the country-road car sensor, a pedestrian request and an emergency preempt. It sits between the intersection sensors and the lamp drivers, and a slow timebase strobe (`tick`) paces it.

## Interface
Parameters:
- `MIN_HWY_GREEN`, default 8: minimum highway green, in ticks.
- `MAX_CTRY_GREEN`, default 16: maximum country green, in ticks.
- `YELLOW_TIME`, default 3: yellow duration, in ticks, for either road.
- `ALL_RED_TIME`, default 2: all-red clearance, in ticks.
- `WALK_TIME`, default 4: walk duration and minimum country green, in ticks. Must satisfy WALK_TIME ≤ MAX_CTRY_GREEN.
- `CNT_W`, default 8: dwell timer width. Every time parameter must be in the range 1..2^CNT_W.

Ports (clock and reset first):
- `clk`  input  1  clock.
- `clr`  input  1  reset, asynchronous, active-high.
- `tick`  input  1  timebase enable, one-cycle strobe.
- `car_sense`  input  1  car present on the country road (level).
- `ped_req`  input  1  pedestrian request (pulse or level; latched).
- `preempt`  input  1  emergency preempt (level); forces the highway to green.
- `hwy`  output  2  highway signal: RED=2'b00, YELLOW=2'b01, GREEN=2'b10.
- `contry`  output  2  country signal, same encoding.
- `walk`  output  1  pedestrian walk indication.
- `phase`  output  3  current state encoding.

## Operation
States and encodings: HG=0, HY=1, AR1=2, CG=3, CY=4, AR2=5.

Lamp decode per state:
- HG: hwy GREEN, contry RED.
- HY: hwy YELLOW, contry RED.
- AR1 and AR2: both RED.
- CG: hwy RED, contry GREEN.
- CY: hwy RED, contry YELLOW.
- Codes 6 and 7: both RED, and the next clock goes to HG.

Dwell timer:
- Cleared to 0 on every state entry.
- Advances only on cycles where `tick`=1.
- For a fixed-length state of N ticks: on a tick, if timer==N-1 the block transitions; otherwise the timer increments.

Transitions (all evaluated only on `tick` cycles):
- HG: timer increments up to MIN_HWY_GREEN-1, then saturates. Exit to HY on a tick when timer==MIN_HWY_GREEN-1, (`car_sense` or `ped_pending`), and `preempt`=0. While `preempt`=1 the block holds HG.
- HY: lasts YELLOW_TIME ticks, then goes to AR1.
- AR1: lasts ALL_RED_TIME ticks. Next state is CG, or AR2 if `preempt`=1 on the exit tick.
- CG: exit to CY on a tick when any of these holds:
  - `preempt`=1;
  - timer==MAX_CTRY_GREEN-1;
  - `car_sense`=0 and timer ≥ WALK_TIME-1.
- CY: lasts YELLOW_TIME ticks, then goes to AR2.
- AR2: lasts ALL_RED_TIME ticks, then goes to HG.

Pedestrian request:
- `ped_pending` sets on any cycle with `ped_req`=1, whether or not `tick`=1.
- It clears on the clock that enters CG.
- If `ped_req`=1 on that same clock, the set wins.
- `walk` = (state==CG) and (timer < WALK_TIME).

Other rules:
- Lamp decode is Moore logic from the state register only. No lamp output depends combinationally on an input.
- `tick`=0 freezes both state and timer. `ped_pending` capture continues.

## Timing
- Reset values: state HG, timer 0, `ped_pending`=0. Outputs: `hwy`=GREEN, `contry`=RED, `walk`=0, `phase`=0. They take effect asynchronously on `clr` rising, including mid-sequence.
- Latency: outputs change on the clock edge that samples the deciding tick, i.e. one clock after the tick cycle.
- State durations with `tick` every cycle:
  - HG: at least MIN_HWY_GREEN cycles.
  - HY and CY: exactly YELLOW_TIME cycles each.
  - AR1 and AR2: exactly ALL_RED_TIME cycles each.
  - CG: between WALK_TIME and MAX_CTRY_GREEN cycles. Preempt cuts it to 1 cycle.
- `hwy` and `contry` are never both non-RED in any cycle.
- Simultaneous CG exit conditions resolve to CY; there is no priority difference between them.
- `car_sense` is ignored in HY, AR1, CY and AR2.

## Test plan
Unless a scenario says otherwise: default parameters, `tick` held at 1.

- **Car arrival:** reset, then hold `car_sense`=1. Required response:
  - HG lasts 8 cycles;
  - HY lasts 3 cycles (`hwy`=01);
  - AR1 lasts 2 cycles (both 00);
  - CG lasts 16 cycles (`contry`=10), then CY 3, AR2 2, then back to HG.
- **Early country exit:** drop `car_sense` to 0 on entry to CG -> CG lasts exactly 4 cycles, with `walk`=1 for all 4.
- **Pedestrian only:** `car_sense`=0, one-cycle `ped_req` pulse at cycle 2 -> HY is entered after cycle 8. In CG, `walk`=1 for 4 cycles and `ped_pending`=0 after CG entry. A second pulse on the CG-entry clock leaves `ped_pending`=1.
- **Preempt:**
  - `preempt`=1 in HG with `car_sense`=1 -> stays HG indefinitely;
  - `preempt` raised during AR1 -> AR1 goes to AR2 and CG is never entered;
  - `preempt` raised in CG at timer=2 -> CY on the next clock.
- **Tick scaling:** `tick` every 4th cycle -> every state duration is ×4 (HY = 12 cycles), and `tick`=0 holds `phase` and the timer constant.
- **Async reset:** assert `clr` mid-CG with `clk` stopped -> `hwy`=10, `contry`=00, `walk`=0, `phase`=0 immediately. Also force `phase` to 6 -> both RED for one cycle, then HG.
